// File: rtl/hms_pkg.sv
// hms_pkg: set-mode encodings, field limits and 7-segment glyphs shared by hms_clock_hex
package hms_pkg;
    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10,
        MODE_SET_SEC = 2'b11
    } mode_e;
    localparam logic [5:0] HR_LIM  = 6'd24;
    localparam logic [5:0] MIN_LIM = 6'd60;
    // Glyphs are active-high {g,f,e,d,c,b,a}; polarity is applied in the encoder
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        case (d)
            4'd0: seg_glyph = SEG_0;
            4'd1: seg_glyph = SEG_1;
            4'd2: seg_glyph = SEG_2;
            4'd3: seg_glyph = SEG_3;
            4'd4: seg_glyph = SEG_4;
            4'd5: seg_glyph = SEG_5;
            4'd6: seg_glyph = SEG_6;
            4'd7: seg_glyph = SEG_7;
            4'd8: seg_glyph = SEG_8;
            4'd9: seg_glyph = SEG_9;
            default: seg_glyph = SEG_BLANK;
        endcase
    endfunction
    // Binary 0..63 to {tens, ones}; field values never exceed 59
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] t;
        t = v / 6'd10;
        return {4'(t), 4'(v - t * 6'd10)};
    endfunction
endpackage

// File: rtl/hex_digit_enc.sv
// hex_digit_enc: one BCD digit to a {dp,g,f,e,d,c,b,a} segment drive
// Ports: bcd (digit 0-9), blank (segments off, dp unaffected), dp (light the point), seg (drive)
module hex_digit_enc
    import hms_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);
    logic [7:0] raw;
    always_comb begin
        raw = {dp, blank ? SEG_BLANK : seg_glyph(bcd)};
        seg = SEG_ACTIVE_LOW ? ~raw : raw;
    end
endmodule

// File: rtl/hms_clock_hex.sv
// hms_clock_hex: free-running HH:MM:SS clock with switch set mode driving six 7-segment digits
// Ports: CLOCK_50/reset (sync, active-high); run_en gates time; set_mode/set_val/set_stb load a field;
//        mode_12h selects 12 h display; tick_1hz pulses each counted second; pm = hr >= 12;
//        hex1:hex0 seconds, hex3:hex2 minutes, hex5:hex4 hours.
// Optional: define HMS_ALARM_EN to add alarm_sel (route set_stb to alarm hh:mm) and alarm output.
module hms_clock_hex
    import hms_pkg::*;
#(
    parameter int TICK_DIV         = 50000000,
    parameter bit BLINK_EN_DEFAULT = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       run_en,
    input  logic [1:0] set_mode,
    input  logic [5:0] set_val,
    input  logic       set_stb,
    input  logic       mode_12h,
`ifdef HMS_ALARM_EN
    input  logic       alarm_sel,
    output logic       alarm,
`endif
    output logic       tick_1hz,
    output logic       pm,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic [7:0] hex3,
    output logic [7:0] hex4,
    output logic [7:0] hex5
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    mode_e      mode;
    logic       run_cnt, tick, ld_ok, al_wr, blink_off, tick_q;
    logic [5:0] lim, hr_disp, blank, dp;
    logic [PW-1:0] presc_q, presc_d, blink_q, blink_d;
    logic [5:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
    logic [3:0] bcd [6];
    logic [7:0] hex_d [6];
    logic [7:0] hex_q [6];
    always_comb begin
        mode = mode_e'(set_mode);
        run_cnt = run_en && mode == MODE_RUN;
        tick = run_cnt && presc_q == PW'(TICK_DIV - 1);
        lim = mode == MODE_SET_HR ? HR_LIM : MIN_LIM;
        ld_ok = set_stb && mode != MODE_RUN && set_val < lim;
        presc_d = !run_cnt ? presc_q : tick ? '0 : presc_q + PW'(1);
        blink_d = blink_q == PW'(TICK_DIV - 1) ? '0 : blink_q + PW'(1);
        sec_d = sec_q;
        min_d = min_q;
        hr_d = hr_q;
        // Carry ripples within one cycle so 23:59:59 rolls straight to 00:00:00
        if (tick) begin
            sec_d = sec_q == 6'd59 ? '0 : sec_q + 6'd1;
            if (sec_q == 6'd59) begin
                min_d = min_q == 6'd59 ? '0 : min_q + 6'd1;
                if (min_q == 6'd59)
                    hr_d = hr_q == 6'd23 ? '0 : hr_q + 6'd1;
            end
        end
        if (ld_ok && !al_wr) begin
            hr_d = mode == MODE_SET_HR ? set_val : hr_d;
            min_d = mode == MODE_SET_MIN ? set_val : min_d;
            sec_d = mode == MODE_SET_SEC ? set_val : sec_d;
            // A fresh seconds value starts a full second from now
            presc_d = mode == MODE_SET_SEC ? '0 : presc_d;
        end
    end
    assign pm = hr_q >= 6'd12;
    assign tick_1hz = tick_q;
    always_comb begin
        hr_disp = !mode_12h ? hr_q : hr_q == 6'd0 ? 6'd12 : hr_q > 6'd12 ? hr_q - 6'd12 : hr_q;
        {bcd[1], bcd[0]} = to_bcd(sec_q);
        {bcd[3], bcd[2]} = to_bcd(min_q);
        {bcd[5], bcd[4]} = to_bcd(hr_disp);
        blink_off = BLINK_EN_DEFAULT && mode != MODE_RUN && blink_q >= PW'(TICK_DIV / 2);
        blank = {{2{blink_off && mode == MODE_SET_HR}}, {2{blink_off && mode == MODE_SET_MIN}},
                 {2{blink_off && mode == MODE_SET_SEC}}};
        // hex4/hex2 points act as separators; hex0 point flags PM in 12 h mode
        dp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, pm && mode_12h};
    end
    for (genvar g = 0; g < 6; g++) begin : g_dig
        hex_digit_enc #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dig (
            .bcd(bcd[g]),
            .blank(blank[g]),
            .dp(dp[g]),
            .seg(hex_d[g])
        );
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc_q <= '0;
            blink_q <= '0;
            sec_q <= '0;
            min_q <= '0;
            hr_q <= '0;
            tick_q <= 1'b0;
            hex_q <= '{default: SEG_OFF};
        end else begin
            presc_q <= presc_d;
            blink_q <= blink_d;
            sec_q <= sec_d;
            min_q <= min_d;
            hr_q <= hr_d;
            tick_q <= tick;
            hex_q <= hex_d;
        end
    end
    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
`ifdef HMS_ALARM_EN
    logic [5:0] al_hr_q, al_hr_d, al_min_q, al_min_d;
    assign al_wr = alarm_sel && (mode == MODE_SET_HR || mode == MODE_SET_MIN);
    always_comb begin
        al_hr_d = ld_ok && al_wr && mode == MODE_SET_HR ? set_val : al_hr_q;
        al_min_d = ld_ok && al_wr && mode == MODE_SET_MIN ? set_val : al_min_q;
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            al_hr_q <= '0;
            al_min_q <= '0;
        end else begin
            al_hr_q <= al_hr_d;
            al_min_q <= al_min_d;
        end
    end
    assign alarm = run_en && hr_q == al_hr_q && min_q == al_min_q;
`else
    assign al_wr = 1'b0;
`endif
endmodule

// File: doc/hms_clock_hex.md
Name: hms_clock_hex

Overview:
- Parametrised hardware time-of-day clock (HH:MM:SS) that drives six 7-segment digits directly. No CPU involvement.
- Prescaler turns CLOCK_50 into a 1 Hz tick that advances a seconds/minutes/hours carry chain.
- Switch-driven set mode with blinking of the field being set; 12/24 h display.
- Sits between board switches/keys and HEX0..HEX5 as the hardware successor to the CPU-driven clock display.

Parameters:
- TICK_DIV, 50000000, CLOCK_50 cycles per second (benches override with a small value).
- BLINK_EN_DEFAULT, 1, 1 = blank the field being set during the second half of each second.
- SEG_ACTIVE_LOW, 1, 1 = segment/DP drive is active-low (0 lights the segment).

Ports:
- CLOCK_50  in  1  system clock; the single clock domain.
- reset  in  1  synchronous, active-high reset.
- run_en  in  1  1 = time advances; 0 = prescaler and time hold.
- set_mode  in  2  00 run, 01 set hours, 10 set minutes, 11 set seconds.
- set_val  in  6  binary value for the selected field.
- set_stb  in  1  one-cycle load strobe.
- mode_12h  in  1  1 = 12 h display, 0 = 24 h display.
- tick_1hz  out  1  one-cycle pulse per counted second.
- pm  out  1  1 when hours >= 12 (valid in both display modes).
- hex0..hex5  out  8 each  segments {dp,g,f,e,d,c,b,a}; hex1:hex0 = seconds, hex3:hex2 = minutes, hex5:hex4 = hours.

Behaviour:
- Reset (synchronous, active-high):
  - Time 00:00:00, prescaler 0, tick_1hz 0, pm 0.
  - hex0..hex5 = all segments off (8'hFF when SEG_ACTIVE_LOW).
  - Reset mid-operation discards any set in progress.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run_en=1 and set_mode=00; otherwise holds.
  - At TICK_DIV-1 it wraps to 0 and tick_1hz pulses for exactly one cycle.
- Time chain, evaluated on a tick:
  - sec increments; at 59 it wraps to 0 and carries into min.
  - min increments; at 59 it wraps to 0 and carries into hr.
  - hr increments; at 23 it wraps to 0.
  - 23:59:59 goes to 00:00:00 in a single cycle.
- Set:
  - When set_mode!=00, time is frozen and the prescaler holds.
  - A set_stb loads set_val into the selected field when set_val < limit (24 for hours, 60 otherwise).
  - An out-of-range set_val is ignored; the field is unchanged.
  - Loading seconds also clears the prescaler.
  - set_stb with set_mode=00 is ignored.
  - set_stb and tick in the same cycle cannot both take effect: a tick requires set_mode=00, and set requires set_mode!=00.
- Display, registered (one cycle latency from counter change to hex outputs):
  - Binary fields are converted to two BCD digits each.
  - 12 h mode: displayed hour 0 shows as 12; hours 13..23 show hr-12. Internal hr is always 24 h.
  - DP is lit on hex2 and hex4 as separators, and on hex0 when pm=1 in 12 h mode. All other DPs are off.
  - Leading zeros are shown.
- Blink:
  - While set_mode!=00 and BLINK_EN_DEFAULT=1, the selected digit pair is blanked (DP kept) when the free-running blink counter >= TICK_DIV/2.
  - The blink counter runs independently of run_en so blinking continues while frozen.

Optional Feature:
- HMS_ALARM_EN defined:
  - Adds input alarm_sel (1) and output alarm (1), plus alarm hour/minute registers (reset 00:00).
  - With alarm_sel=1, set_stb under set_mode 01/10 writes the alarm fields instead of the time fields.
  - alarm is high while hr:min equals the alarm time and run_en=1. It therefore asserts on the tick reaching ss=00 and clears when the minute changes.
- Not defined: no extra ports and no alarm logic.

Decomposition:
- Package hms_pkg:
  - Mode constants MODE_RUN/SET_HR/SET_MIN/SET_SEC.
  - Limits HR_LIM=24, MIN_LIM=60.
  - 7-segment pattern constants for digits 0-9 and SEG_BLANK.
- Sub-module hex_digit_enc: 4-bit BCD plus blank plus dp in, 8-bit segment out, polarity per SEG_ACTIVE_LOW. Instantiated six times.

Test Plan (TICK_DIV=4):
- Reset, run_en=1, 12 cycles -> tick_1hz pulses on cycles 4, 8 and 12; seconds reach 03; hex0=8'hB0 ('3') and hex1=8'hC0 ('0') one cycle after each change.
- Set 23:59:58 via set_mode 01/10/11 with set_val 23, 59, 58, then run 8 cycles -> 00:00:00; pm falls 1->0; all hex show '0' with DPs on hex2/hex4.
- set_mode=10, set_val=60, set_stb -> minutes unchanged; set_val=45 -> minutes=45; hex3/hex2 blank during the second half of each blink period.
- mode_12h=1, time 00:15:00 -> hex5:hex4 show "12"; at 13:05:00 they show "01" with pm=1 and hex0 DP lit.
- run_en=0 for 20 cycles -> no tick_1hz and time unchanged; reset asserted mid-set -> outputs 8'hFF the next cycle, then time 00:00:00.
- HMS_ALARM_EN: alarm set to 00:01, run from 00:00:58 -> alarm rises with the tick to 00:01:00 and falls on the tick to 00:02:00.
